// File: rtl/nor_chain_pulse_sweeper_if.sv
// Bus bundle between the test/configuration logic and the NOR-chain pulse sweeper.
// The master side is the tester; the slave side is the sweeper itself.
interface nor_chain_pulse_sweeper_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] cfg_min_w;
    logic [W-1:0] cfg_max_w;
    logic [W-1:0] cfg_step;
    logic [W-1:0] cfg_gap;
    logic         chain_out;
    logic         chain_in;
    logic         chain_gnd;
    logic         busy;
    logic         done;
    logic         res_valid;
    logic [W-1:0] res_width;
    logic [3:0]   res_edges;

    modport master (
        output start, cfg_min_w, cfg_max_w, cfg_step, cfg_gap, chain_out,
        input  chain_in, chain_gnd, busy, done, res_valid, res_width, res_edges
    );

    modport slave (
        input  start, cfg_min_w, cfg_max_w, cfg_step, cfg_gap, chain_out,
        output chain_in, chain_gnd, busy, done, res_valid, res_width, res_edges
    );
endinterface

// File: rtl/nor_chain_pulse_sweeper.sv
// Stimulus-and-capture controller for the six-stage NOR chain: parks, settles, sweeps
// pulse widths and counts synchronized output rising edges per pulse.
module nor_chain_pulse_sweeper #(
    parameter int W          = 8,
    parameter int SETTLE_CYC = 8
) (
    input  logic                         myclk,
    input  logic                         myrst,
    nor_chain_pulse_sweeper_if.slave     bus
);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = (SW > W) ? SW : W;
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYC - 1);
    localparam logic [W-1:0]  ONE_W       = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_PULSE  = 3'd2,
        S_GAP    = 3'd3,
        S_REPORT = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [TW-1:0] tmr_r, tmr_nxt_s;
    logic [W-1:0]  cur_w_r, cur_w_nxt_s;
    logic [W-1:0]  min_r, max_r, step_r, gap_r;
    logic [W:0]    sum_s;
    logic [3:0]    cnt_r, cnt_nxt_s;
    logic          sync1_r, sync2_r, sync3_r, edge_r;
    logic          chain_in_r, chain_gnd_r, busy_r, done_r, res_valid_r;
    logic [W-1:0]  res_width_r;
    logic [3:0]    res_edges_r;

    // Zero-valued width/step/gap settings behave as 1.
    function automatic logic [W-1:0] nz(input logic [W-1:0] v);
        return (v == {W{1'b0}}) ? ONE_W : v;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    // Synchronizer and rising-edge detect for the asynchronous chain output.
    always_ff @(posedge myclk) begin
        if (myrst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
            edge_r  <= 1'b0;
        end else begin
            sync1_r <= bus.chain_out;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
            edge_r  <= sync2_r & ~sync3_r;
        end
    end

    // Sequencer next-state, phase timer, current width and edge counter.
    always_comb begin
        state_nxt_s = state_r;
        tmr_nxt_s   = tmr_r;
        cur_w_nxt_s = cur_w_r;
        sum_s       = {1'b0, cur_w_r} + {1'b0, step_r};
        if ((state_r == S_PULSE || state_r == S_GAP) && edge_r) begin
            cnt_nxt_s = sat_inc(cnt_r);
        end else begin
            cnt_nxt_s = cnt_r;
        end
        case (state_r)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt_s = S_SETTLE;
                    tmr_nxt_s   = SETTLE_LOAD;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (tmr_r != {TW{1'b0}}) begin
                    tmr_nxt_s = tmr_r - {{(TW-1){1'b0}}, 1'b1};
                end else if (min_r > max_r) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_PULSE;
                    cur_w_nxt_s = min_r;
                    tmr_nxt_s   = TW'(min_r - ONE_W);
                    cnt_nxt_s   = 4'd0;
                end
            end
            S_PULSE: begin
                if (tmr_r != {TW{1'b0}}) begin
                    tmr_nxt_s = tmr_r - {{(TW-1){1'b0}}, 1'b1};
                end else begin
                    state_nxt_s = S_GAP;
                    tmr_nxt_s   = TW'(gap_r - ONE_W);
                end
            end
            S_GAP: begin
                if (tmr_r != {TW{1'b0}}) begin
                    tmr_nxt_s = tmr_r - {{(TW-1){1'b0}}, 1'b1};
                end else begin
                    state_nxt_s = S_REPORT;
                end
            end
            S_REPORT: begin
                // Width arithmetic is one bit wider so a wrap past 2^W-1 ends the sweep.
                if (sum_s[W] || (sum_s > {1'b0, max_r})) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_PULSE;
                    cur_w_nxt_s = sum_s[W-1:0];
                    tmr_nxt_s   = TW'(sum_s[W-1:0] - ONE_W);
                    cnt_nxt_s   = 4'd0;
                end
            end
            S_DONE: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Sequencer state, working registers and configuration captured at start.
    always_ff @(posedge myclk) begin
        if (myrst) begin
            state_r <= S_IDLE;
            tmr_r   <= {TW{1'b0}};
            cur_w_r <= {W{1'b0}};
            cnt_r   <= 4'd0;
            min_r   <= ONE_W;
            max_r   <= {W{1'b0}};
            step_r  <= ONE_W;
            gap_r   <= ONE_W;
        end else begin
            state_r <= state_nxt_s;
            tmr_r   <= tmr_nxt_s;
            cur_w_r <= cur_w_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (state_r == S_IDLE && bus.start) begin
                min_r  <= nz(bus.cfg_min_w);
                max_r  <= bus.cfg_max_w;
                step_r <= nz(bus.cfg_step);
                gap_r  <= nz(bus.cfg_gap);
            end
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge myclk) begin
        if (myrst) begin
            chain_gnd_r <= 1'b1;
            chain_in_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            res_valid_r <= 1'b0;
            res_width_r <= {W{1'b0}};
            res_edges_r <= 4'd0;
        end else begin
            chain_gnd_r <= (state_nxt_s == S_IDLE);
            chain_in_r  <= (state_nxt_s == S_PULSE);
            busy_r      <= (state_nxt_s != S_IDLE);
            done_r      <= (state_nxt_s == S_DONE);
            res_valid_r <= (state_nxt_s == S_REPORT);
            if (state_nxt_s == S_REPORT) begin
                res_width_r <= cur_w_r;
                res_edges_r <= cnt_nxt_s;
            end
        end
    end

    assign bus.chain_in  = chain_in_r;
    assign bus.chain_gnd = chain_gnd_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_width = res_width_r;
    assign bus.res_edges = res_edges_r;
endmodule

// File: doc/nor_chain_pulse_sweeper.md
# nor_chain_pulse_sweeper

Synchronous stimulus-and-capture controller for the six-stage NOR inverter chain used in delay-model evaluation.
- Parks the chain by driving its shared gnd input high.
- Releases the chain and settles it, then launches a sweep of input pulses of increasing width, from a programmed minimum to a maximum in programmed steps.
- Counts the output rising edges that reach the clock domain for each pulse and reports one result per pulse.
- Sits between the test/configuration logic and the chain's myin/mygnd/myout pins.

## Interface
Parameters:
- W, 8: width of all width/step/gap configuration values and of the internal width counter.
- SETTLE_CYC, 8: cycles the chain is held released with input low before the first pulse (minimum 1).

Ports (clock and reset first):
- myclk  in  1  clock; all logic on rising edge.
- myrst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; ignored while busy.
- cfg_min_w  in  W  first pulse width, in cycles; 0 is treated as 1.
- cfg_max_w  in  W  last permitted pulse width.
- cfg_step  in  W  width increment; 0 is treated as 1.
- cfg_gap  in  W  low cycles after each pulse (observation tail); 0 is treated as 1.
- chain_out  in  1  chain output (myout), asynchronous to myclk.
- chain_in  out  1  drives chain myin.
- chain_gnd  out  1  drives chain mygnd; 1 = chain parked (all stages 0), 0 = chain active.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when the sweep ends.
- res_valid  out  1  one-cycle strobe; the res_* outputs are valid.
- res_width  out  W  width of the pulse being reported.
- res_edges  out  4  synchronized rising edges seen in the pulse window; saturates at 15.

## Operation
- Configuration is captured on the accepted start cycle. Later changes to cfg_* have no effect until the next start.
- chain_out passes through a 2-flop synchronizer and then an edge-detect register. A rising edge is counted 3 cycles after it arrives.
- States and transitions:
  - IDLE: chain_gnd=1, chain_in=0, busy=0. Goes to SETTLE on start.
  - SETTLE: chain_gnd=0, chain_in=0 for SETTLE_CYC cycles. Then:
    - if effective min > max, goes to DONE with no results;
    - otherwise loads cur_w = effective min and goes to PULSE.
  - PULSE: chain_in=1 for exactly cur_w cycles. The edge counter clears on entry. Goes to GAP.
  - GAP: chain_in=0 for effective gap cycles. Goes to REPORT.
  - REPORT: one cycle with res_valid=1, res_width=cur_w, res_edges=count. Then computes cur_w + step in W+1 bits:
    - if the sum exceeds cfg_max_w or 2^W−1, goes to DONE;
    - otherwise cur_w takes the sum and the state goes to PULSE.
  - DONE: one cycle with done=1, busy=1, chain_gnd=0. Goes to IDLE.
- Edge counting window:
  - Edges are counted only while in PULSE or GAP. Edges detected in any other state are discarded.
  - Sizing cfg_gap to cover chain delay plus the 3-cycle synchronizer latency is the user's responsibility.
- res_width and res_edges hold their last values outside res_valid.
- Reset, including mid-sweep, forces IDLE on the next edge:
  - chain_gnd=1, chain_in=0;
  - busy=0, done=0, res_valid=0, res_width=0, res_edges=0;
  - synchronizer and counters cleared;
  - no done pulse is generated.

## Timing
- Reset values: chain_gnd=1; all other outputs 0.
- If start is accepted in cycle 0:
  - busy=1 and chain_gnd=0 from cycle 1;
  - the first chain_in high is cycle 1+SETTLE_CYC.
- Each pulse occupies cur_w + gap + 1 cycles, with res_valid in the last of them.
- The next pulse's chain_in rises in the cycle after res_valid.
- done asserts in the cycle after the final res_valid. If min > max, it asserts in cycle 1+SETTLE_CYC.
- IDLE (busy=0, chain_gnd=1) begins in the cycle after done.
- A start asserted while busy, including during the done cycle, is dropped.

## Test plan
- Loopback: chain_out tied to chain_in; min=2, max=6, step=2, gap=10 -> three res_valid with width 2/4/6 and edges 1/1/1; done 1 cycle after the third; total busy length 8+13+15+17+1.
- Stuck output: chain_out=0; min=1, max=3, step=1 -> widths 1, 2, 3, all edges 0; chain_gnd=0 during the sweep and 1 afterward.
- Glitch/saturation: bench drives 3 separated chain_out pulses in one window -> edges=3; drives 20 pulses -> edges=15. An edge injected during SETTLE is not counted.
- Boundaries:
  - W=8, min=250, step=4, max=255 -> widths 250, 254, then done (overflow terminates);
  - min=9, max=4 -> no res_valid, done at cycle 1+SETTLE_CYC;
  - step=0 and gap=0 behave as 1.
- Reset mid-PULSE (width 5, cycle 3) -> next cycle chain_in=0, chain_gnd=1, busy=0, no done. A fresh start then runs the full sweep correctly.
- start while busy and cfg_* changed mid-sweep -> ignored; results match the config captured at the original start.
